gf2m_mul_seq: RTL and testbench
===============================

# gf2m_mul_seq

Bit-serial GF(2^m) multiplication sequencer that sits directly upstream of `gf2m_alu`. It drives the ALU's `add`/`shl`/`sto` strobes and `sbus` operand to compute `result = a·b mod f(x)`, MSB-first interleaved (shift, conditionally reduce, conditionally add). It uses the ALU's `dbus` as the accumulator and the ALU's registered carry-out `mz` as the reduction trigger.

## Interface
- `WORD_WIDTH`, 256: datapath width; must match the ALU.
- `M`, 233: field degree, 2 ≤ M ≤ WORD_WIDTH.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: request; sampled only when not `busy`.
- `a`, `b` in WORD_WIDTH: operands, left-aligned (coefficient of x^k at bit WORD_WIDTH-M+k).
- `poly` in WORD_WIDTH: reduction polynomial f(x) minus its x^m term, left-aligned.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse, result valid.
- `result` out WORD_WIDTH: product, left-aligned, held until the next `done`.
- `alu_add`, `alu_shl`, `alu_sto` out 1: ALU command strobes, at most one high per cycle.
- `alu_sbus` out WORD_WIDTH: ALU source operand.
- `alu_dbus` in WORD_WIDTH: ALU accumulator.
- `alu_mz` in 1: ALU registered MSB of last operand.
- `alu_eq` in 1: ALU accumulator is zero.
- `alu_run` in 1: ALU busy; add/shl are not accepted while it is high.

## Operation
- Reset values: `busy`, `done`, all strobes 0; `alu_sbus` and `result` all-zero; state IDLE.
- On `start` in IDLE or DONE: capture `a`, `b`, `poly` with bits [WORD_WIDTH-M-1:0] forced to 0, set bit index i=M-1, go to CLR.
- **CLR**: `alu_sto`=1, `alu_sbus`=0. Next state: SHL.
- **SHL**: `alu_shl`=1, `alu_sbus`=`alu_dbus`. Next state: SHLW.
- **SHLW**: no strobe. Branch, evaluated in this order:
  - `alu_mz` → RED.
  - else b bit i set → ADD.
  - else → NEXT.
- **RED**: `alu_add`=1, `alu_sbus`=poly. Next state: REDW.
- **REDW**: no strobe. b bit i set → ADD; else → NEXT.
- **ADD**: `alu_add`=1, `alu_sbus`=a. Next state: ADDW.
- **ADDW**: no strobe. → NEXT.
- **NEXT**: combinational. i=0 → DONE; else decrement i and enter SHL in the same cycle.
- **DONE**: `done`=1, `result`←`alu_dbus`, `busy`=0. Next: CLR if `start`, else IDLE.
- `busy`=1 in every state except IDLE and DONE. `start` while busy is ignored.
- Stall rule: in SHL/RED/ADD with `alu_run`=1, all strobes are 0 and the state holds.
- `alu_sbus` is 0 in all states other than SHL/RED/ADD/CLR.
- Arithmetic is all XOR and shift. The shift carry-out (bit WORD_WIDTH-1) is x^m; it is folded back via `poly`. Low pad bits stay 0.

## Timing
- Start accepted at edge 0; CLR occupies cycle 1.
- Each bit costs 2 + 2·r_i + 2·b_i cycles (r_i = reduction taken).
- `done` is high in cycle 2 + Σ(2 + 2r_i + 2b_i), plus any stall cycles.
- `result` updates on the edge ending the DONE cycle.
- Asynchronous `reset` mid-operation: immediate return to IDLE, strobes drop with no glitch-free guarantee, `result` cleared. The ALU is expected to share `reset`.

## Configuration
- `GF2M_MUL_SKIPZ_EN` defined:
  - In SHL with `alu_eq`=1, no shl is issued; mz is taken as 0.
  - Branch as SHLW in the same cycle, so a zero-accumulator bit costs 1 cycle.
  - Not constant-time.
- Undefined: every bit always issues shl; timing depends only on the reductions taken and b.

## Test plan
- a=0, b=0, default params → `done` at cycle 468; `result`=0; ALU receives 233 shl, 0 add.
- a=1<<23 (element 1), b=random left-aligned X → `result`=X.
- poly=(1<<97)|(1<<23) (x^74+1), a=1<<24 (x), b=1<<255 (x^232) → `result`=(1<<97)|(1<<23); exactly one RED.
- `start` re-pulsed at cycle 50 → ignored; `reset` at cycle 100 → `busy`/`done`/strobes 0 at once; next start yields correct product.
- `alu_run` forced 1 for 3 cycles in SHL → strobes 0, state held, `done` delayed by exactly 3 cycles, result unchanged.
- With `GF2M_MUL_SKIPZ_EN`, a=b=1<<23 → `done` at cycle 237 (470 without), `result`=1<<23.

Source files
------------

// File: rtl/gf2m_mul_seq.sv
// Bit-serial GF(2^m) multiply sequencer driving gf2m_alu (MSB-first shift/reduce/add).
// Optional GF2M_MUL_SKIPZ_EN: skip shl while the accumulator is zero (not constant-time).
module gf2m_mul_seq #(
    parameter int WORD_WIDTH = 256,
    parameter int M          = 233
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  logic [WORD_WIDTH-1:0] poly_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WORD_WIDTH-1:0] result_o,
    output logic                  alu_add_o,
    output logic                  alu_shl_o,
    output logic                  alu_sto_o,
    output logic [WORD_WIDTH-1:0] alu_sbus_o,
    input  logic [WORD_WIDTH-1:0] alu_dbus_i,
    input  logic                  alu_mz_i,
    input  logic                  alu_eq_i,
    input  logic                  alu_run_i
);

    localparam int IW = $clog2(M);
    localparam logic [WORD_WIDTH-1:0] COEF_MASK = {WORD_WIDTH{1'b1}} << (WORD_WIDTH - M);

    typedef enum logic [3:0] {
        IDLE, CLR, SHL, SHLW, RED, REDW, ADD, ADDW, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         i_q, i_d;
    logic [WORD_WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  adv;
    logic                  skip;

`ifdef GF2M_MUL_SKIPZ_EN
    assign skip = alu_eq_i;
`else
    logic unused_eq;
    assign unused_eq = alu_eq_i;
    assign skip      = 1'b0;
`endif

    // b_q is shifted left per bit so the current coefficient b_i is always its MSB.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        adv      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) result_d = alu_dbus_i;
                if (start_i) begin
                    a_d     = a_i & COEF_MASK;
                    b_d     = b_i & COEF_MASK;
                    p_d     = poly_i & COEF_MASK;
                    i_d     = IW'(M - 1);
                    busy_d  = 1'b1;
                    state_d = CLR;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            CLR: state_d = SHL;
            SHL: begin
                if (!alu_run_i) begin
                    if (skip) begin
                        if (b_q[WORD_WIDTH-1]) state_d = ADD;
                        else                   adv     = 1'b1;
                    end else begin
                        state_d = SHLW;
                    end
                end
            end
            SHLW: begin
                if (alu_mz_i)               state_d = RED;
                else if (b_q[WORD_WIDTH-1]) state_d = ADD;
                else                        adv     = 1'b1;
            end
            RED: if (!alu_run_i) state_d = REDW;
            REDW: begin
                if (b_q[WORD_WIDTH-1]) state_d = ADD;
                else                   adv     = 1'b1;
            end
            ADD:  if (!alu_run_i) state_d = ADDW;
            ADDW: adv = 1'b1;
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (i_q == '0) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                i_d     = i_q - 1'b1;
                b_d     = b_q << 1;
                state_d = SHL;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            i_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Strobes decode straight from the state register; alu_run only gates issue.
    always_comb begin
        alu_sto_o  = (state_q == CLR);
        alu_shl_o  = (state_q == SHL) && !alu_run_i && !skip;
        alu_add_o  = ((state_q == RED) || (state_q == ADD)) && !alu_run_i;
        alu_sbus_o = '0;
        case (state_q)
            SHL:     alu_sbus_o = alu_dbus_i;
            RED:     alu_sbus_o = p_q;
            ADD:     alu_sbus_o = a_q;
            default: alu_sbus_o = '0;
        endcase
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_gf2m_mul_seq.sv
// Scoreboard bench for gf2m_mul_seq with a behavioural gf2m_alu model.
module tb_gf2m_mul_seq;
    localparam int W = 256;
    localparam logic [W-1:0] ONE  = 256'd1 << 23;
    localparam logic [W-1:0] XV   = 256'd1 << 24;
    localparam logic [W-1:0] POLY = (256'd1 << 97) | (256'd1 << 23);
    localparam logic [W-1:0] X1 = 256'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1357_9BDF_2468_ACE0_0000_0000;
    localparam logic [W-1:0] X2 = 256'h8000_0001_F0F0_0F0F_3C3C_C3C3_5555_AAAA_1111_2222_4444_8888_9999_6666_0080_0000;
`ifdef GF2M_MUL_SKIPZ_EN
    localparam int LAT_ZERO = 235;
    localparam int LAT_ONE  = 237;
    localparam int LAT_RED  = -1;
    localparam int SHL_ZERO = 0;
    localparam bit SKIPZ    = 1'b1;
`else
    localparam int LAT_ZERO = 468;
    localparam int LAT_ONE  = 470;
    localparam int LAT_RED  = 472;
    localparam int SHL_ZERO = 233;
    localparam bit SKIPZ    = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0, poly = '0;
    logic         busy, done, add, shl, sto;
    logic [W-1:0] result, sbus;
    logic [W-1:0] dbus;
    logic         mz;
    logic         run = 1'b0;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0, ops_done = 0, ops_exp = 0;
    int n_shl = 0, n_add = 0, n_red = 0;

    typedef struct { logic [W-1:0] res; int lat; } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    gf2m_mul_seq #(.WORD_WIDTH(W), .M(233)) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start),
        .a_i(a), .b_i(b), .poly_i(poly),
        .busy_o(busy), .done_o(done), .result_o(result),
        .alu_add_o(add), .alu_shl_o(shl), .alu_sto_o(sto), .alu_sbus_o(sbus),
        .alu_dbus_i(dbus), .alu_mz_i(mz), .alu_eq_i(dbus == '0), .alu_run_i(run)
    );

    // ALU model: sto loads, shl shifts with carry into mz, add XORs into the accumulator.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus <= '0;
            mz   <= 1'b0;
        end else if (sto) begin
            dbus <= sbus;
        end else if (shl) begin
            dbus  <= sbus << 1;
            mz    <= sbus[W-1];
            n_shl <= n_shl + 1;
        end else if (add) begin
            dbus  <= dbus ^ sbus;
            mz    <= sbus[W-1];
            n_add <= n_add + 1;
            if (sbus == POLY) n_red <= n_red + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: pop expected entry on every done pulse, check latency then the registered result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.lat >= 0) check("done_cycle", W'(cyc - t0 + 1), W'(e.lat));
                    @(posedge clk);
                    #1;
                    check("result", result, e.res);
                end
                ops_done++;
            end
        end
    end

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] res, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; poly = POLY; start = 1'b1;
        if (push) begin
            e.res = res; e.lat = lat;
            exp_q.push_back(e);
            ops_exp++;
        end
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done();
        int k = 0;
        while (ops_done < ops_exp && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (ops_done < ops_exp) check("timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic wait_cycle(input int c);
        while (cyc - t0 + 1 < c) @(negedge clk);
    endtask

    initial begin
        int s0, a0, r0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_strobes", W'({add, shl, sto}), 0);
        check("rst_sbus", sbus, 0);
        check("rst_result", result, 0);
        rst = 1'b0;

        // 0 * 0
        s0 = n_shl; a0 = n_add;
        start_op('0, '0, '0, LAT_ZERO, 1'b1);
        check("clr_busy", W'(busy), 1);
        check("clr_sto", W'({add, shl, sto}), 1);
        wait_done();
        check("zero_shl_count", W'(n_shl - s0), W'(SHL_ZERO));
        check("zero_add_count", W'(n_add - a0), 0);

        // 1 * X1 with no reductions: each set bit of X1 costs one add pair
        start_op(ONE, X1, X1, SKIPZ ? -1 : 468 + 2 * $countones(X1), 1'b1);
        wait_done();

        // x * x^232 = x^233 = poly
        a0 = n_add; r0 = n_red;
        start_op(XV, 256'd1 << 255, POLY, LAT_RED, 1'b1);
        wait_done();
        check("red_count", W'(n_red - r0), 1);
        check("red_add_count", W'(n_add - a0), 2);

        // start re-pulsed mid-operation must be ignored
        start_op(ONE, X2, X2, SKIPZ ? -1 : 468 + 2 * $countones(X2), 1'b1);
        wait_cycle(50);
        a = '0; b = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("repulse_busy", W'(busy), 1);
        wait_done();

        // asynchronous reset mid-operation
        start_op(ONE, X1, '0, -1, 1'b0);
        wait_cycle(100);
        rst = 1'b1;
        #1;
        check("arst_busy", W'(busy), 0);
        check("arst_done", W'(done), 0);
        check("arst_strobes", W'({add, shl, sto}), 0);
        check("arst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        start_op(ONE, ONE, ONE, LAT_ONE, 1'b1);
        wait_done();

        // alu_run held for 3 cycles in the first SHL
        start_op(ONE, ONE, ONE, LAT_ONE + 3, 1'b1);
        wait_cycle(2);
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_strobes", W'({add, shl, sto}), 0);
            check("stall_sbus", sbus, dbus);
            @(negedge clk);
        end
        run = 1'b0;
        wait_done();

        check("queue_empty", W'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
